// File: rtl/odometer_rosc_ctrl.sv
// Odometer ring-oscillator bank controller: sequences one channel through stress
// or measure mode and reports synchronised reference/stress edge counts.
module odometer_rosc_ctrl #(
   parameter int  NCH        = 4,
   parameter int  CNT_W      = 16,
   parameter int  WIN_W      = 16,
   parameter int  SETTLE_CYC = 8,
   localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             MODE,
   input  logic [CH_W-1:0]  CH_SEL,
   input  logic [WIN_W-1:0] WIN_LEN,
   input  logic             ABORT,
   input  logic [NCH-1:0]   RO_REF_IN,
   input  logic [NCH-1:0]   RO_STR_IN,
   output logic [NCH-1:0]   RO_EN_REF,
   output logic [NCH-1:0]   RO_EN_STR,
   output logic [NCH-1:0]   STRESS_EN,
   output logic             BUSY,
   output logic             DONE,
   output logic [CNT_W-1:0] CNT_REF,
   output logic [CNT_W-1:0] CNT_STR,
   output logic [CNT_W:0]   CNT_DIFF,
   output logic             OVF
);

   localparam int SET_W = $clog2(SETTLE_CYC + 1);
   localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETTLE  = 3'd1,
      S_MEASURE = 3'd2,
      S_STRESS  = 3'd3,
      S_FINISH  = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_load;
   logic             w_cap;
   logic [CH_W-1:0]  r_ch;
   logic [CH_W-1:0]  w_ch_nxt;
   logic [NCH-1:0]   w_oh_nxt;
   logic [WIN_W-1:0] r_win;
   logic [TMR_W-1:0] r_tmr;
   logic             w_settle_last;
   logic             w_win_last;
   logic             w_win_zero;
   logic             w_on_nxt;

   logic [NCH-1:0]   r_ref_s1, r_ref_s2, r_ref_s3;
   logic [NCH-1:0]   r_str_s1, r_str_s2, r_str_s3;
   logic [NCH-1:0]   w_ref_edges, w_str_edges;
   logic             w_ref_hit, w_str_hit;

   logic [CNT_W-1:0] r_cnt_ref, r_cnt_str;
   logic [CNT_W-1:0] w_ref_nxt, w_str_nxt;
   logic             r_ovf, w_ovf_nxt;

   logic [NCH-1:0]   r_en_ref, r_en_str, r_stress_en;
   logic             r_busy, r_done;
   logic [CNT_W-1:0] r_out_ref, r_out_str;
   logic [CNT_W:0]   r_out_diff;
   logic             r_out_ovf;

   function automatic logic [NCH-1:0] f_onehot(input logic [CH_W-1:0] ch);
      logic [NCH-1:0] v;
      for (int i = 0; i < NCH; i++) begin
         if (int'(ch) == i) v[i] = 1'b1;
         else               v[i] = 1'b0;
      end
      return v;
   endfunction

   assign w_settle_last = (r_tmr == TMR_W'(SETTLE_CYC - 1));
   assign w_win_last    = (r_tmr == (TMR_W'(r_win) - TMR_W'(1)));
   assign w_win_zero    = (r_win == '0);

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (START && (int'(CH_SEL) < NCH)) begin
               w_load = 1'b1;
               if (MODE) w_state_nxt = S_STRESS;
               else      w_state_nxt = S_SETTLE;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_SETTLE: begin
            if (ABORT)              w_state_nxt = S_IDLE;
            else if (!w_settle_last) w_state_nxt = S_SETTLE;
            else if (w_win_zero)    w_state_nxt = S_FINISH;
            else                    w_state_nxt = S_MEASURE;
         end
         S_MEASURE: begin
            if (ABORT)           w_state_nxt = S_IDLE;
            else if (w_win_last) w_state_nxt = S_FINISH;
            else                 w_state_nxt = S_MEASURE;
         end
         S_STRESS: begin
            if (ABORT) w_state_nxt = S_FINISH;
            else       w_state_nxt = S_STRESS;
         end
         S_FINISH: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Stress exit keeps the previous results; only measure paths capture
   assign w_cap    = (w_state_nxt == S_FINISH) && (r_state != S_STRESS);
   assign w_ch_nxt = w_load ? CH_SEL : r_ch;
   assign w_oh_nxt = f_onehot(w_ch_nxt);
   assign w_on_nxt = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_MEASURE);

   assign w_ref_edges = r_ref_s2 & ~r_ref_s3;
   assign w_str_edges = r_str_s2 & ~r_str_s3;
   assign w_ref_hit   = w_ref_edges[r_ch];
   assign w_str_hit   = w_str_edges[r_ch];

   // Edge-counter next values: cleared in SETTLE, saturating in MEASURE
   always_comb begin
      w_ref_nxt = r_cnt_ref;
      w_str_nxt = r_cnt_str;
      w_ovf_nxt = r_ovf;
      case (r_state)
         S_SETTLE: begin
            w_ref_nxt = '0;
            w_str_nxt = '0;
            w_ovf_nxt = 1'b0;
         end
         S_MEASURE: begin
            if (w_ref_hit && (r_cnt_ref != CNT_MAX)) w_ref_nxt = r_cnt_ref + CNT_W'(1);
            else                                     w_ref_nxt = r_cnt_ref;
            if (w_str_hit && (r_cnt_str != CNT_MAX)) w_str_nxt = r_cnt_str + CNT_W'(1);
            else                                     w_str_nxt = r_cnt_str;
            w_ovf_nxt = r_ovf | (w_ref_nxt == CNT_MAX) | (w_str_nxt == CNT_MAX);
         end
         default: begin
            w_ovf_nxt = r_ovf;
         end
      endcase
   end

   // State, channel/window latch, phase timer
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_ch    <= '0;
         r_win   <= '0;
         r_tmr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ch    <= w_ch_nxt;
         if (w_load) r_win <= WIN_LEN;
         if ((w_state_nxt != r_state) || !((r_state == S_SETTLE) || (r_state == S_MEASURE)))
            r_tmr <= '0;
         else
            r_tmr <= r_tmr + TMR_W'(1);
      end
   end

   // RO synchronisers and edge counters
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_ref_s1  <= '0;
         r_ref_s2  <= '0;
         r_ref_s3  <= '0;
         r_str_s1  <= '0;
         r_str_s2  <= '0;
         r_str_s3  <= '0;
         r_cnt_ref <= '0;
         r_cnt_str <= '0;
         r_ovf     <= 1'b0;
      end else begin
         r_ref_s1  <= RO_REF_IN;
         r_ref_s2  <= r_ref_s1;
         r_ref_s3  <= r_ref_s2;
         r_str_s1  <= RO_STR_IN;
         r_str_s2  <= r_str_s1;
         r_str_s3  <= r_str_s2;
         r_cnt_ref <= w_ref_nxt;
         r_cnt_str <= w_str_nxt;
         r_ovf     <= w_ovf_nxt;
      end
   end

   // Registered enables, status and results, decoded from the next state
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_en_ref    <= '0;
         r_en_str    <= '0;
         r_stress_en <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_out_ref   <= '0;
         r_out_str   <= '0;
         r_out_diff  <= '0;
         r_out_ovf   <= 1'b0;
      end else begin
         r_en_ref    <= w_on_nxt ? w_oh_nxt : '0;
         r_en_str    <= (w_on_nxt || (w_state_nxt == S_STRESS)) ? w_oh_nxt : '0;
         r_stress_en <= (w_state_nxt == S_STRESS) ? w_oh_nxt : '0;
         r_busy      <= w_on_nxt || (w_state_nxt == S_STRESS);
         r_done      <= (w_state_nxt == S_FINISH);
         if (w_cap) begin
            r_out_ref  <= w_ref_nxt;
            r_out_str  <= w_str_nxt;
            r_out_diff <= {1'b0, w_ref_nxt} - {1'b0, w_str_nxt};
            r_out_ovf  <= w_ovf_nxt;
         end
      end
   end

   assign RO_EN_REF = r_en_ref;
   assign RO_EN_STR = r_en_str;
   assign STRESS_EN = r_stress_en;
   assign BUSY      = r_busy;
   assign DONE      = r_done;
   assign CNT_REF   = r_out_ref;
   assign CNT_STR   = r_out_str;
   assign CNT_DIFF  = r_out_diff;
   assign OVF       = r_out_ovf;

endmodule
